// File: rtl/pipeline_stage_fifo_pkg.sv
// Shared constants for the core's inter-stage buffers: stage-bundle layouts,
// atomic-op encoding and the bubble payloads loaded into empty or squashed stages.
package pipeline_stage_fifo_pkg;

    localparam int FIFO_MAX_DEPTH = 8;

    typedef enum logic [3:0] {
        ATOMIC_LR    = 4'h0,
        ATOMIC_SC    = 4'h1,
        ATOMIC_SWAP  = 4'h2,
        ATOMIC_ADD   = 4'h3,
        ATOMIC_AND   = 4'h4,
        ATOMIC_OR    = 4'h5,
        ATOMIC_XOR   = 4'h6,
        ATOMIC_MAX   = 4'h7,
        ATOMIC_MIN   = 4'h8,
        ATOMIC_NO_OP = 4'hF
    } atomic_op_e;

    // EX/MEM bundle, LSB first: result, rs2, rd, ctrl, atomic_op
    localparam int EXMEM_RESULT_LSB = 0;
    localparam int EXMEM_RESULT_W   = 32;
    localparam int EXMEM_RS2_LSB    = 32;
    localparam int EXMEM_RS2_W      = 32;
    localparam int EXMEM_RD_LSB     = 64;
    localparam int EXMEM_RD_W       = 5;
    localparam int EXMEM_CTRL_LSB   = 69;
    localparam int EXMEM_CTRL_W     = 6;
    localparam int EXMEM_ATOMIC_LSB = 75;
    localparam int EXMEM_ATOMIC_W   = 4;
    localparam int EXMEM_W          = 79;

    // MEM/WB bundle, LSB first: result, rd, ctrl
    localparam int MEMWB_RESULT_LSB = 0;
    localparam int MEMWB_RESULT_W   = 32;
    localparam int MEMWB_RD_LSB     = 32;
    localparam int MEMWB_RD_W       = 5;
    localparam int MEMWB_CTRL_LSB   = 37;
    localparam int MEMWB_CTRL_W     = 6;
    localparam int MEMWB_W          = 43;

    typedef struct packed {
        atomic_op_e                atomic_op;
        logic [EXMEM_CTRL_W-1:0]   ctrl;
        logic [EXMEM_RD_W-1:0]     rd;
        logic [EXMEM_RS2_W-1:0]    rs2;
        logic [EXMEM_RESULT_W-1:0] result;
    } exmem_bundle_t;

    typedef struct packed {
        logic [MEMWB_CTRL_W-1:0]   ctrl;
        logic [MEMWB_RD_W-1:0]     rd;
        logic [MEMWB_RESULT_W-1:0] result;
    } memwb_bundle_t;

    // A bubble writes nothing (ctrl=0, rd=x0) and must not start an atomic.
    localparam exmem_bundle_t EXMEM_BUBBLE_S = '{
        atomic_op: ATOMIC_NO_OP,
        ctrl:      6'h00,
        rd:        5'h00,
        rs2:       32'h0000_0000,
        result:    32'h0000_0000
    };
    localparam logic [EXMEM_W-1:0] EXMEM_BUBBLE = EXMEM_BUBBLE_S;

    localparam memwb_bundle_t MEMWB_BUBBLE_S = '{
        ctrl:   6'h00,
        rd:     5'h00,
        result: 32'h0000_0000
    };
    localparam logic [MEMWB_W-1:0] MEMWB_BUBBLE = MEMWB_BUBBLE_S;

    // Pointer width for a buffer of the given depth; a single-entry buffer still needs one bit.
    function automatic int ptr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pipeline_stage_fifo.sv
// Elastic pipeline register: DEPTH-entry in-order buffer with valid/ready handshake,
// synchronous flush and a bubble payload presented whenever the buffer is empty.
module pipeline_stage_fifo
    import pipeline_stage_fifo_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter int               DEPTH         = 1,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE  = '0,
    parameter bit               BYPASS_READY  = 1'b1,
    parameter bit               RESET_STORAGE = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_payload,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_payload,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_in_ready;
    logic w_push;
    logic w_pop;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Handshake decode; in_ready deliberately ignores in_valid and flush.
    always_comb begin
        w_empty    = (r_count == {CNT_W{1'b0}});
        w_full     = (r_count == FULL_CNT);
        w_in_ready = !w_full || (BYPASS_READY && out_ready && !w_empty);
        w_pop      = !w_empty && out_ready;
        w_push     = in_valid && w_in_ready && !flush;
    end

    // Pointer and count state; reset and flush both return to the empty state.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; optionally scrubbed to the bubble so stale ops never linger.
    always_ff @(posedge clock) begin
        if (RESET_STORAGE && (reset || flush)) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= BUBBLE_VALUE;
            end
        end else if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= in_payload;
        end
    end

    // Outputs come only from stored state, so there is no in->out combinational path.
    always_comb begin
        in_ready    = w_in_ready;
        out_valid   = !w_empty;
        out_payload = w_empty ? BUBBLE_VALUE : r_mem[r_rd_ptr];
        occupancy   = r_count;
    end

endmodule

// File: tb/tb_pipeline_stage_fifo.sv
// Bench for pipeline_stage_fifo: three configurations share one stimulus stream and are
// checked every cycle against queue-based models, plus directed literal expectations.
module tb_pipeline_stage_fifo;

    localparam int W = 16;

    logic           clock = 1'b0;
    logic           reset;
    logic           flush;
    logic           in_valid;
    logic           out_ready;
    logic [W-1:0]   in_payload;

    logic           ir [3];
    logic           ov [3];
    logic [W-1:0]   op [3];
    logic [0:0]     occ_u0;
    logic [1:0]     occ_u1;
    logic [1:0]     occ_u2;
    logic [31:0]    occ [3];

    int             n_vec = 0;
    int             n_err = 0;
    bit             model_live = 1'b0;
    logic [W-1:0]   mq [3][$];

    always #5 clock = ~clock;

    pipeline_stage_fifo #(.WIDTH(W), .DEPTH(1), .BUBBLE_VALUE(16'hB0B0),
                          .BYPASS_READY(1'b1), .RESET_STORAGE(1'b1)) u0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_payload(in_payload),
        .out_valid(ov[0]), .out_ready(out_ready), .out_payload(op[0]),
        .occupancy(occ_u0));

    pipeline_stage_fifo #(.WIDTH(W), .DEPTH(3), .BUBBLE_VALUE(16'hDEAD),
                          .BYPASS_READY(1'b1), .RESET_STORAGE(1'b0)) u1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_payload(in_payload),
        .out_valid(ov[1]), .out_ready(out_ready), .out_payload(op[1]),
        .occupancy(occ_u1));

    pipeline_stage_fifo #(.WIDTH(W), .DEPTH(2), .BUBBLE_VALUE(16'h0BAD),
                          .BYPASS_READY(1'b0), .RESET_STORAGE(1'b1)) u2 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]), .in_payload(in_payload),
        .out_valid(ov[2]), .out_ready(out_ready), .out_payload(op[2]),
        .occupancy(occ_u2));

    always_comb begin
        occ[0] = 32'(occ_u0);
        occ[1] = 32'(occ_u1);
        occ[2] = 32'(occ_u2);
    end

    function automatic int dep(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit byp(input int k);
        return (k != 2);
    endfunction

    function automatic logic [W-1:0] bub(input int k);
        case (k)
            0:       return 16'hB0B0;
            1:       return 16'hDEAD;
            default: return 16'h0BAD;
        endcase
    endfunction

    function automatic bit model_ready(input int k);
        return (mq[k].size() < dep(k)) || (byp(k) && out_ready && (mq[k].size() > 0));
    endfunction

    function automatic bit model_push(input int k);
        return in_valid && model_ready(k) && !flush;
    endfunction

    function automatic bit model_pop(input int k);
        return (mq[k].size() > 0) && out_ready;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Reference model: one FIFO queue per instance, updated on each rising edge.
    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                mq[k].delete();
            end
            model_live <= 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (flush) begin
                    mq[k].delete();
                end else begin
                    case ({model_push(k), model_pop(k)})
                        2'b11: begin
                            void'(mq[k].pop_front());
                            mq[k].push_back(in_payload);
                        end
                        2'b10:   mq[k].push_back(in_payload);
                        2'b01:   void'(mq[k].pop_front());
                        default: ;
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (model_live) begin
            for (int k = 0; k < 3; k++) begin
                check("out_valid", k, 32'(ov[k]), 32'(mq[k].size() > 0));
                check("out_payload", k, 32'(op[k]), 32'((mq[k].size() > 0) ? mq[k][0] : bub(k)));
                check("occupancy", k, occ[k], 32'(mq[k].size()));
                check("in_ready", k, 32'(ir[k]), 32'(model_ready(k)));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] p, input logic ordy, input logic fl);
        in_valid   = v;
        in_payload = p;
        out_ready  = ordy;
        flush      = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 16'h1234, 1'b0, 1'b0);

        // Reset held two cycles with in_valid high.
        tick();
        tick();
        @(negedge clock);
        check("rst_valid", 0, 32'(ov[0]), 32'h0);
        check("rst_bubble", 0, 32'(op[0]), 32'hB0B0);
        check("rst_bubble", 1, 32'(op[1]), 32'hDEAD);
        check("rst_bubble", 2, 32'(op[2]), 32'h0BAD);
        check("rst_occ", 1, occ[1], 32'h0);
        check("rst_ready", 2, 32'(ir[2]), 32'h1);
        tick();
        reset = 1'b0;

        // Streaming through the single-entry instance.
        drive(1'b1, 16'h0011, 1'b1, 1'b0);
        @(negedge clock);
        check("s_valid0", 0, 32'(ov[0]), 32'h0);
        tick();
        drive(1'b1, 16'h0022, 1'b1, 1'b0);
        @(negedge clock);
        check("s_out11", 0, 32'(op[0]), 32'h0011);
        check("s_ready", 0, 32'(ir[0]), 32'h1);
        tick();
        drive(1'b1, 16'h0033, 1'b1, 1'b0);
        @(negedge clock);
        check("s_out22", 0, 32'(op[0]), 32'h0022);
        check("s_ready", 0, 32'(ir[0]), 32'h1);
        tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clock);
        check("s_out33", 0, 32'(op[0]), 32'h0033);
        tick();
        tick();

        // Back-pressure on the three-entry instance; 0xD must be refused.
        drive(1'b1, 16'h000A, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h000B, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h000C, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h000D, 1'b0, 1'b0);
        @(negedge clock);
        check("bp_occ", 1, occ[1], 32'h3);
        check("bp_ready", 1, 32'(ir[1]), 32'h0);
        check("bp_head", 1, 32'(op[1]), 32'h000A);
        tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clock);
        check("bp_outA", 1, 32'(op[1]), 32'h000A);
        tick();
        @(negedge clock);
        check("bp_outB", 1, 32'(op[1]), 32'h000B);
        tick();
        @(negedge clock);
        check("bp_outC", 1, 32'(op[1]), 32'h000C);
        tick();
        @(negedge clock);
        check("bp_drained", 1, 32'(ov[1]), 32'h0);
        tick();

        // Pointer wrap: two held entries while 1..7 stream through.
        drive(1'b1, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0002, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(i + 3), 1'b1, 1'b0);
            @(negedge clock);
            check("wrap_out", 1, 32'(op[1]), 32'(i + 1));
            check("wrap_occ", 1, occ[1], 32'h2);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clock);
        check("wrap_out6", 1, 32'(op[1]), 32'h0006);
        tick();
        @(negedge clock);
        check("wrap_out7", 1, 32'(op[1]), 32'h0007);
        tick();
        tick();

        // Flush of a full two-entry buffer while 0x7 is offered.
        drive(1'b1, 16'h0005, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0006, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0007, 1'b0, 1'b1);
        @(negedge clock);
        check("fl_occ_before", 2, occ[2], 32'h2);
        check("fl_ready_full", 2, 32'(ir[2]), 32'h0);
        tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clock);
        check("fl_valid", 2, 32'(ov[2]), 32'h0);
        check("fl_bubble", 2, 32'(op[2]), 32'h0BAD);
        check("fl_occ", 2, occ[2], 32'h0);
        check("fl_ready", 2, 32'(ir[2]), 32'h1);
        check("fl_valid", 1, 32'(ov[1]), 32'h0);
        tick();
        tick();

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 800; c++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)),
                  1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 5));
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
